// File: rtl/decomp_pkg.sv
// Shared types and constants for the code decompressor front end.
// Codewords are 16-bit halfwords; bit 15 separates tokens from escapes.
package decomp_pkg;

  localparam int HALF         = 16;
  localparam int CW_TOKEN_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MWAIT,
    PARSE,
    ESC_LO,
    ESC_HI,
    LOOKUP,
    OUT
  } state_t;

endpackage

// File: rtl/decomp_outreg.sv
// Output holding register towards the decoder.
// Holds instruction and pc stable while the decoder stalls.
module decomp_outreg
  import decomp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [SIZE-1:0]  pc,
  input  logic             ready,
  output logic [WIDTH-1:0] instr_o,
  output logic [SIZE-1:0]  instr_pc,
  output logic             instr_valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_o     <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_o     <= data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (instr_valid && ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/decomp_ctrl_unit.sv
// Decompressor control: fetches packed code words, expands tokens
// through the token table and assembles escaped 32-bit instructions.
module decomp_ctrl_unit
  import decomp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 23,
  parameter int TOKEN_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [SIZE-1:0]       redirect_addr,
  output logic                  mem_req,
  output logic [SIZE-2:0]       mem_addr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  tt_rd,
  output logic [TOKEN_BITS-1:0] tt_idx,
  input  logic [WIDTH-1:0]      tt_data,
  output logic [WIDTH-1:0]      instr_o,
  output logic [SIZE-1:0]       instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  state_t            state;
  state_t            resume;
  logic [SIZE-1:0]   hw_ptr;
  logic [SIZE-1:0]   ptr_inc;
  logic [SIZE-1:0]   start_pc;
  logic [WIDTH-1:0]  wbuf;
  logic [HALF-1:0]   lo_half;
  logic [HALF-1:0]   hw;
  logic              have;
  logic              is_token;
  logic              load;
  logic [WIDTH-1:0]  load_data;

  assign hw       = hw_ptr[0] ? wbuf[WIDTH-1:HALF] : wbuf[HALF-1:0];
  assign is_token = hw[CW_TOKEN_BIT];
  assign ptr_inc  = hw_ptr + SIZE'(1);

  assign mem_req  = (state == FETCH);
  assign mem_addr = hw_ptr[SIZE-1:1];
  assign tt_rd    = (state == PARSE) && is_token;
  assign tt_idx   = hw[TOKEN_BITS-1:0];

  assign load      = (state == ESC_HI) || (state == LOOKUP);
  assign load_data = (state == LOOKUP) ? tt_data : {hw, lo_half};

  // have: wbuf still holds the word that hw_ptr points into
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      resume   <= PARSE;
      hw_ptr   <= '0;
      start_pc <= '0;
      wbuf     <= '0;
      lo_half  <= '0;
      have     <= 1'b0;
    end else if (redirect) begin
      state  <= FETCH;
      resume <= PARSE;
      hw_ptr <= redirect_addr;
      have   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: state <= MWAIT;
        MWAIT: begin
          wbuf  <= mem_rdata;
          have  <= 1'b1;
          state <= resume;
        end
        PARSE: begin
          start_pc <= hw_ptr;
          hw_ptr   <= ptr_inc;
          have     <= ptr_inc[0];
          if (is_token) begin
            state <= LOOKUP;
          end else if (ptr_inc[0]) begin
            state <= ESC_LO;
          end else begin
            state  <= FETCH;
            resume <= ESC_LO;
          end
        end
        ESC_LO: begin
          lo_half <= hw;
          hw_ptr  <= ptr_inc;
          have    <= ptr_inc[0];
          if (ptr_inc[0]) begin
            state <= ESC_HI;
          end else begin
            state  <= FETCH;
            resume <= ESC_HI;
          end
        end
        ESC_HI: begin
          hw_ptr <= ptr_inc;
          have   <= ptr_inc[0];
          state  <= OUT;
        end
        LOOKUP: state <= OUT;
        OUT: begin
          if (instr_ready) begin
            resume <= PARSE;
            state  <= have ? PARSE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  decomp_outreg #(
    .WIDTH(WIDTH),
    .SIZE (SIZE)
  ) u_outreg (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .load       (load),
    .data       (load_data),
    .pc         (start_pc),
    .ready      (instr_ready),
    .instr_o    (instr_o),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid)
  );

endmodule
